l1_tlul_mem_bridge: RTL and testbench
=====================================

Name: l1_tlul_mem_bridge

Overview:
- Sits directly downstream of the L1 data cache, on its memory-side req/gnt/rvalid port.
- Converts each accepted cache request into a TileLink-UL channel A message and consumes channel D responses.
- TileLink may return responses out of order. The block reorders them and returns read data to the cache strictly in issue order.
- Provides up to MAX_OUTSTANDING in-flight transactions.

Parameters:
- MAX_OUTSTANDING, 4: number of reorder slots; must be a power of 2, range 2..16.
- SRC_W, 2: a_source/d_source width; must equal log2(MAX_OUTSTANDING).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_i  in  1  cache request; held until gnt_o
- we_i  in  1  1 = write, 0 = read
- be_i  in  8  write byte enables
- addr_i  in  64  byte address
- wdata_i  in  64  write data
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  read data valid; one-cycle pulse per read
- rdata_o  out  64  read data
- a_valid_o  out  1  TL A valid
- a_ready_i  in  1  TL A ready
- a_opcode_o  out  3  Get=4, PutFullData=0, PutPartialData=1
- a_param_o  out  3  always 0
- a_size_o  out  3  always 3 (8 bytes)
- a_source_o  out  SRC_W  slot index
- a_address_o  out  64  {addr_i[63:3],3'b000}
- a_mask_o  out  8  read: 8'hFF; write: be_i
- a_data_o  out  64  wdata_i; 0 on reads
- d_valid_i  in  1  TL D valid
- d_ready_o  out  1  TL D ready
- d_opcode_i  in  3  AccessAck=0, AccessAckData=1
- d_source_i  in  SRC_W  slot being answered
- d_data_i  in  64  response data
- d_denied_i  in  1  TL denied
- d_corrupt_i  in  1  TL corrupt
- idle_o  out  1  no slot busy

Behaviour:
- Slot state: per slot busy, is_read, done, data[63:0]. Pointers alloc_ptr and ret_ptr are SRC_W bits wide and wrap modulo MAX_OUTSTANDING.
- Request side:
  - a_valid_o = req_i & ~busy[alloc_ptr]; combinational, independent of a_ready_i.
  - gnt_o = a_valid_o & a_ready_i.
  - On gnt_o: mark the slot busy, record is_read = ~we_i, increment alloc_ptr.
  - a_source_o = alloc_ptr.
  - Write opcode: PutFullData if be_i == 8'hFF, else PutPartialData. be_i == 0 still issues PutPartialData with mask 0.
  - Full condition: busy[alloc_ptr] = 1 → a_valid_o = 0 and gnt_o = 0; req_i stalls.
- Response side:
  - d_ready_o = 1 always, since space is reserved at allocation.
  - On d_valid_i: set done[d_source_i] and capture d_data_i into that slot.
  - D arriving for a non-busy slot is dropped with no state change.
- Retire:
  - Each cycle, if busy[ret_ptr] and (done[ret_ptr] or a D beat arriving for ret_ptr this cycle): free the slot and increment ret_ptr.
  - If that slot is a read: rvalid_o <= 1 and rdata_o <= slot data (or the bypassed d_data_i) at the next edge.
  - Write slots retire silently; rvalid_o is never asserted for writes.
  - At most one retire per cycle.
- Latency:
  - Read with D at ret_ptr handshaking on cycle N → rvalid_o high in cycle N+1.
  - Out-of-order D waits until every older slot retires.
- Simultaneous events:
  - Allocation into a slot and retire of a different slot in the same cycle are both honoured.
  - A slot freed this cycle is allocatable from the next cycle.
- idle_o = no busy bits set (combinational).
- Reset: all busy/done cleared; pointers 0; rvalid_o 0; rdata_o 0; err_o 0. Reset mid-transaction abandons all slots; D beats arriving after reset are dropped as non-busy.
- Outputs a_* are combinational from req_i/addr_i/we_i/be_i/wdata_i/alloc_ptr.

Optional Feature:
- Macro: L1_TLUL_BRIDGE_ERR_EN.
- Enabled:
  - Each slot stores an err bit = d_denied_i | d_corrupt_i.
  - Output err_o (1 bit) is registered and pulses together with retire, for reads and writes, when the slot's err is set.
  - Read data on error is forced to 64'h0.
- Disabled: no err_o port; d_denied_i/d_corrupt_i are ignored and data passes through unmodified.

Test Plan:
- Read miss fill: read addr 0x1000, D AccessAckData source 0 data 0x1122334455667788 after 3 cycles → a_opcode 4, a_address 0x1000, a_mask FF; rvalid_o one cycle after D with rdata 0x1122334455667788.
- Partial write: write addr 0x200C be 0xF0 wdata 0xBEEFBEEF00000000 → a_opcode 1, a_address 0x2008, a_mask F0; gnt_o; AccessAck retires with no rvalid. Write be FF → opcode 0.
- Reorder: reads to 0x1000 and 0x1008 (sources 0,1); D for source 1 (0xB) then source 0 (0xA) → rvalid sequence 0xA, then 0xB in the following cycle.
- Full: issue 4 reads with no D → 5th req sees a_valid_o = 0 and gnt_o = 0 until source-0 D arrives; granted the cycle after retire, with a_source 0 (wrap).
- Backpressure: a_ready_i low 5 cycles → a_valid_o held with stable payload, gnt_o low, no slot allocated; grant on the first ready cycle.
- Reset and error: reset with 2 outstanding → idle_o = 1, late D dropped, no rvalid. With ERR_EN, read D d_denied = 1 → rvalid with rdata 0 and err_o = 1.

Source files
------------

// File: rtl/l1_tlul_mem_bridge.sv
// l1_tlul_mem_bridge
// Bridges the L1 data cache memory port (req/gnt/rvalid) onto TileLink-UL.
// Each granted request takes a reorder slot whose index is the A-channel
// source. D responses may come back in any order; they are parked in their
// slot and retired strictly in issue order, so read data returns in order.
//
// Optional build macro: L1_TLUL_BRIDGE_ERR_EN
//   When defined, d_denied_i/d_corrupt_i are recorded per slot, err_o pulses
//   on retire of an errored slot, and read data of an errored read is zeroed.

module l1_tlul_mem_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned SRC_W           = 2
) (
    input  logic             clk,
    input  logic             rst_n,

    // cache-side request port
    input  logic             req_i,
    input  logic             we_i,
    input  logic [7:0]       be_i,
    input  logic [63:0]      addr_i,
    input  logic [63:0]      wdata_i,
    output logic             gnt_o,
    output logic             rvalid_o,
    output logic [63:0]      rdata_o,

    // TileLink-UL channel A
    output logic             a_valid_o,
    input  logic             a_ready_i,
    output logic [2:0]       a_opcode_o,
    output logic [2:0]       a_param_o,
    output logic [2:0]       a_size_o,
    output logic [SRC_W-1:0] a_source_o,
    output logic [63:0]      a_address_o,
    output logic [7:0]       a_mask_o,
    output logic [63:0]      a_data_o,

    // TileLink-UL channel D
    input  logic             d_valid_i,
    output logic             d_ready_o,
    input  logic [2:0]       d_opcode_i,
    input  logic [SRC_W-1:0] d_source_i,
    input  logic [63:0]      d_data_i,
    input  logic             d_denied_i,
    input  logic             d_corrupt_i,

`ifdef L1_TLUL_BRIDGE_ERR_EN
    output logic             err_o,
`endif
    output logic             idle_o
);

    typedef enum logic [2:0] {
        OP_PUT_FULL    = 3'd0,
        OP_PUT_PARTIAL = 3'd1,
        OP_GET         = 3'd4
    } a_opcode_e;

    // ------------------------------------------------------------------
    // Slot storage and pointers
    // ------------------------------------------------------------------
    logic [MAX_OUTSTANDING-1:0] busy_q;
    logic [MAX_OUTSTANDING-1:0] is_read_q;
    logic [MAX_OUTSTANDING-1:0] done_q;
    logic [63:0]                data_q [MAX_OUTSTANDING];
    logic [SRC_W-1:0]           alloc_ptr_q;
    logic [SRC_W-1:0]           ret_ptr_q;

    a_opcode_e                  a_opcode;
    logic                       d_hit;
    logic                       d_at_ret;
    logic                       retire;
    logic                       retire_read;
    logic [63:0]                ret_data;

`ifdef L1_TLUL_BRIDGE_ERR_EN
    logic [MAX_OUTSTANDING-1:0] err_q;
    logic                       d_err;
    logic                       ret_err;
    logic                       unused_inputs;

    assign d_err         = d_denied_i | d_corrupt_i;
    assign unused_inputs = ^{d_opcode_i, addr_i[2:0]};
`else
    logic                       unused_inputs;

    assign unused_inputs = ^{d_opcode_i, addr_i[2:0], d_denied_i, d_corrupt_i};
`endif

    // ------------------------------------------------------------------
    // Request side: A channel is a combinational view of the cache request
    // ------------------------------------------------------------------
    assign a_valid_o   = req_i & ~busy_q[alloc_ptr_q];
    assign gnt_o       = a_valid_o & a_ready_i;
    assign a_param_o   = 3'd0;
    assign a_size_o    = 3'd3;
    assign a_source_o  = alloc_ptr_q;
    assign a_address_o = {addr_i[63:3], 3'b000};
    assign a_opcode_o  = a_opcode;

    // Opcode, mask and data selection for the outgoing A beat
    always_comb begin
        a_opcode = OP_GET;
        a_mask_o = 8'hFF;
        a_data_o = '0;
        if (we_i) begin
            a_opcode = (be_i == 8'hFF) ? OP_PUT_FULL : OP_PUT_PARTIAL;
            a_mask_o = be_i;
            a_data_o = wdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Response side and retire decision
    // ------------------------------------------------------------------
    assign d_ready_o = 1'b1;
    assign d_hit     = d_valid_i & busy_q[d_source_i];
    assign d_at_ret  = d_hit & (d_source_i == ret_ptr_q);
    assign idle_o    = ~|busy_q;

    // Oldest slot retires once answered; a D beat for it this cycle is bypassed
    always_comb begin
        retire      = busy_q[ret_ptr_q] & (done_q[ret_ptr_q] | d_at_ret);
        retire_read = retire & is_read_q[ret_ptr_q];
        ret_data    = done_q[ret_ptr_q] ? data_q[ret_ptr_q] : d_data_i;
`ifdef L1_TLUL_BRIDGE_ERR_EN
        ret_err     = done_q[ret_ptr_q] ? err_q[ret_ptr_q] : d_err;
        if (ret_err) begin
            ret_data = '0;
        end
`endif
    end

    // Slot bookkeeping: allocate on grant, mark done on D, free on retire
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= '0;
            is_read_q   <= '0;
            done_q      <= '0;
            alloc_ptr_q <= '0;
            ret_ptr_q   <= '0;
        end else begin
            // The granted slot is never busy, so it cannot collide with the
            // D-capture or retire updates below, which only touch busy slots.
            if (gnt_o) begin
                busy_q[alloc_ptr_q]    <= 1'b1;
                is_read_q[alloc_ptr_q] <= ~we_i;
                done_q[alloc_ptr_q]    <= 1'b0;
                alloc_ptr_q            <= alloc_ptr_q + SRC_W'(1);
            end
            if (d_hit) begin
                done_q[d_source_i] <= 1'b1;
            end
            // Retire is last so a bypassed D beat does not leave done set
            if (retire) begin
                busy_q[ret_ptr_q] <= 1'b0;
                done_q[ret_ptr_q] <= 1'b0;
                ret_ptr_q         <= ret_ptr_q + SRC_W'(1);
            end
        end
    end

    // Response payload capture into the answered slot
    always_ff @(posedge clk) begin
        if (d_hit) begin
            data_q[d_source_i] <= d_data_i;
        end
    end

`ifdef L1_TLUL_BRIDGE_ERR_EN
    // Per-slot error flag captured alongside the response payload
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (d_hit) begin
            err_q[d_source_i] <= d_err;
        end
    end

    // Error pulse accompanies the retire of an errored slot, read or write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else begin
            err_o <= retire & ret_err;
        end
    end
`endif

    // Read return to the cache: one-cycle pulse, data held between pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= retire_read;
            if (retire_read) begin
                rdata_o <= ret_data;
            end
        end
    end

endmodule

// File: tb/tb_l1_tlul_mem_bridge.sv
// Self-checking bench for l1_tlul_mem_bridge: table of A-channel decode
// vectors plus hand-written sequences, with an in-order read scoreboard.
// Build with L1_TLUL_BRIDGE_ERR_EN defined to cover the error path.

module tb_l1_tlul_mem_bridge;

    localparam int MAX_OUT = 4;
    localparam int SRC_W   = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_i, we_i;
    logic [7:0]       be_i;
    logic [63:0]      addr_i, wdata_i;
    logic             gnt_o, rvalid_o;
    logic [63:0]      rdata_o;
    logic             a_valid_o, a_ready_i;
    logic [2:0]       a_opcode_o, a_param_o, a_size_o;
    logic [SRC_W-1:0] a_source_o;
    logic [63:0]      a_address_o;
    logic [7:0]       a_mask_o;
    logic [63:0]      a_data_o;
    logic             d_valid_i, d_ready_o;
    logic [2:0]       d_opcode_i;
    logic [SRC_W-1:0] d_source_i;
    logic [63:0]      d_data_i;
    logic             d_denied_i, d_corrupt_i;
    logic             idle_o;
`ifdef L1_TLUL_BRIDGE_ERR_EN
    logic             err_o;
`endif

    l1_tlul_mem_bridge #(
        .MAX_OUTSTANDING(MAX_OUT),
        .SRC_W          (SRC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .we_i       (we_i),
        .be_i       (be_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .a_valid_o  (a_valid_o),
        .a_ready_i  (a_ready_i),
        .a_opcode_o (a_opcode_o),
        .a_param_o  (a_param_o),
        .a_size_o   (a_size_o),
        .a_source_o (a_source_o),
        .a_address_o(a_address_o),
        .a_mask_o   (a_mask_o),
        .a_data_o   (a_data_o),
        .d_valid_i  (d_valid_i),
        .d_ready_o  (d_ready_o),
        .d_opcode_i (d_opcode_i),
        .d_source_i (d_source_i),
        .d_data_i   (d_data_i),
        .d_denied_i (d_denied_i),
        .d_corrupt_i(d_corrupt_i),
`ifdef L1_TLUL_BRIDGE_ERR_EN
        .err_o      (err_o),
`endif
        .idle_o     (idle_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  be;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  op;
        logic [63:0] exp_addr;
        logic [7:0]  exp_mask;
        logic [63:0] exp_data;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;

    vec_t vecs [6];
    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Advance one cycle and score any read return against the expected queue
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rvalid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 64'(rvalid_o), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_rdata", rdata_o, e.data);
`ifdef L1_TLUL_BRIDGE_ERR_EN
                check("sb_err", 64'(err_o), 64'(e.err));
`endif
            end
        end
    endtask

    task automatic push_exp(input logic [63:0] data, input logic err);
        exp_t e;
        e.data = data;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_i = 1'b0;
        d_valid_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic we, input logic [7:0] be, input logic [63:0] addr,
                         input logic [63:0] wdata, output logic [SRC_W-1:0] src);
        logic got;
        got = 1'b0;
        src = '0;
        a_ready_i = 1'b1;
        req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (gnt_o) begin
                got = 1'b1;
                src = a_source_o;
            end
            tick();
        end
        req_i = 1'b0;
        check("issue_gnt", 64'(got), 64'd1);
    endtask

    task automatic send_d(input logic [SRC_W-1:0] src, input logic [63:0] data,
                          input logic [2:0] op, input logic den, input logic cor);
        d_valid_i = 1'b1; d_source_i = src; d_data_i = data; d_opcode_i = op;
        d_denied_i = den; d_corrupt_i = cor;
        tick();
        d_valid_i = 1'b0; d_denied_i = 1'b0; d_corrupt_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SRC_W-1:0] s0, s1, s2, s3;

        rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = '0; addr_i = '0; wdata_i = '0;
        a_ready_i = 1'b1; d_valid_i = 1'b0; d_opcode_i = '0; d_source_i = '0;
        d_data_i = '0; d_denied_i = 1'b0; d_corrupt_i = 1'b0;

        vecs[0] = '{1'b0, 8'h00, 64'h1000, 64'h5555, 3'd4, 64'h1000, 8'hFF, 64'h0};
        vecs[1] = '{1'b0, 8'h3C, 64'h1007, 64'hAAAA, 3'd4, 64'h1000, 8'hFF, 64'h0};
        vecs[2] = '{1'b1, 8'hF0, 64'h200C, 64'hBEEFBEEF00000000, 3'd1, 64'h2008, 8'hF0, 64'hBEEFBEEF00000000};
        vecs[3] = '{1'b1, 8'hFF, 64'h3010, 64'h0123456789ABCDEF, 3'd0, 64'h3010, 8'hFF, 64'h0123456789ABCDEF};
        vecs[4] = '{1'b1, 8'h00, 64'h4000, 64'hCAFE, 3'd1, 64'h4000, 8'h00, 64'hCAFE};
        vecs[5] = '{1'b1, 8'h01, 64'hFFFFFFFFFFFFFFFF, 64'h77, 3'd1, 64'hFFFFFFFFFFFFFFF8, 8'h01, 64'h77};

        // Reset state
        tick();
        tick();
        check("rst_idle", 64'(idle_o), 64'd1);
        check("rst_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_rdata", rdata_o, 64'd0);
        check("rst_a_valid", 64'(a_valid_o), 64'd0);
        check("rst_d_ready", 64'(d_ready_o), 64'd1);
`ifdef L1_TLUL_BRIDGE_ERR_EN
        check("rst_err", 64'(err_o), 64'd0);
`endif
        rst_n = 1'b1;
        tick();

        // A-channel decode table, held off by a_ready_i so nothing allocates
        a_ready_i = 1'b0;
        foreach (vecs[i]) begin
            req_i = 1'b1; we_i = vecs[i].we; be_i = vecs[i].be;
            addr_i = vecs[i].addr; wdata_i = vecs[i].wdata;
            #1;
            check("vec_a_valid", 64'(a_valid_o), 64'd1);
            check("vec_gnt", 64'(gnt_o), 64'd0);
            check("vec_opcode", 64'(a_opcode_o), 64'(vecs[i].op));
            check("vec_address", a_address_o, vecs[i].exp_addr);
            check("vec_mask", 64'(a_mask_o), 64'(vecs[i].exp_mask));
            check("vec_data", a_data_o, vecs[i].exp_data);
            check("vec_param_size", 64'({a_param_o, a_size_o}), 64'h03);
            check("vec_source", 64'(a_source_o), 64'd0);
            tick();
        end
        req_i = 1'b0;
        a_ready_i = 1'b1;
        check("vec_idle", 64'(idle_o), 64'd1);

        // Read miss fill, D three cycles after grant
        push_exp(64'h1122334455667788, 1'b0);
        issue(1'b0, 8'h00, 64'h1000, 64'h0, s0);
        check("fill_src", 64'(s0), 64'd0);
        tick(); tick(); tick();
        check("fill_no_early_rvalid", 64'(rvalid_o), 64'd0);
        send_d(s0, 64'h1122334455667788, 3'd1, 1'b0, 1'b0);
        check("fill_rvalid", 64'(rvalid_o), 64'd1);
        check("fill_rdata", rdata_o, 64'h1122334455667788);
        tick();
        check("fill_rvalid_pulse", 64'(rvalid_o), 64'd0);
        check("fill_idle", 64'(idle_o), 64'd1);

        // Partial and full writes retire silently
        issue(1'b1, 8'hF0, 64'h200C, 64'hBEEFBEEF00000000, s0);
        check("pw_busy", 64'(idle_o), 64'd0);
        send_d(s0, 64'h0, 3'd0, 1'b0, 1'b0);
        check("pw_no_rvalid", 64'(rvalid_o), 64'd0);
        check("pw_idle", 64'(idle_o), 64'd1);
        issue(1'b1, 8'hFF, 64'h2010, 64'h1, s0);
        send_d(s0, 64'h0, 3'd0, 1'b0, 1'b0);
        check("fw_no_rvalid", 64'(rvalid_o), 64'd0);

        // Reorder: younger response first, returns still in issue order
        push_exp(64'hA, 1'b0);
        push_exp(64'hB, 1'b0);
        issue(1'b0, 8'h00, 64'h1000, 64'h0, s0);
        issue(1'b0, 8'h00, 64'h1008, 64'h0, s1);
        send_d(s1, 64'hB, 3'd1, 1'b0, 1'b0);
        check("ro_hold", 64'(rvalid_o), 64'd0);
        send_d(s0, 64'hA, 3'd1, 1'b0, 1'b0);
        check("ro_first_valid", 64'(rvalid_o), 64'd1);
        check("ro_first_data", rdata_o, 64'hA);
        tick();
        check("ro_second_valid", 64'(rvalid_o), 64'd1);
        check("ro_second_data", rdata_o, 64'hB);
        tick();
        check("ro_done", 64'(idle_o), 64'd1);

        // Full: four outstanding reads stall the fifth until slot 0 retires
        do_reset();
        push_exp(64'hD0, 1'b0); push_exp(64'hD1, 1'b0);
        push_exp(64'hD2, 1'b0); push_exp(64'hD3, 1'b0);
        push_exp(64'hD4, 1'b0);
        issue(1'b0, 8'h00, 64'h3000, 64'h0, s0);
        issue(1'b0, 8'h00, 64'h3008, 64'h0, s1);
        issue(1'b0, 8'h00, 64'h3010, 64'h0, s2);
        issue(1'b0, 8'h00, 64'h3018, 64'h0, s3);
        check("full_srcs", 64'({s0, s1, s2, s3}), 64'b00_01_10_11);
        req_i = 1'b1; we_i = 1'b0; addr_i = 64'h3020;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("full_a_valid", 64'(a_valid_o), 64'd0);
            check("full_gnt", 64'(gnt_o), 64'd0);
            tick();
        end
        d_valid_i = 1'b1; d_source_i = s0; d_data_i = 64'hD0; d_opcode_i = 3'd1;
        #1;
        check("full_gnt_during_d", 64'(gnt_o), 64'd0);
        tick();
        d_valid_i = 1'b0;
        check("full_ret_rvalid", 64'(rvalid_o), 64'd1);
        check("full_regrant", 64'(gnt_o), 64'd1);
        check("full_wrap_src", 64'(a_source_o), 64'd0);
        tick();
        req_i = 1'b0;
        send_d(s1, 64'hD1, 3'd1, 1'b0, 1'b0);
        send_d(s2, 64'hD2, 3'd1, 1'b0, 1'b0);
        send_d(s3, 64'hD3, 3'd1, 1'b0, 1'b0);
        send_d(2'd0, 64'hD4, 3'd1, 1'b0, 1'b0);
        check("full_last_data", rdata_o, 64'hD4);
        check("full_idle", 64'(idle_o), 64'd1);

        // Backpressure: payload held stable, nothing allocated until ready
        a_ready_i = 1'b0;
        req_i = 1'b1; we_i = 1'b1; be_i = 8'h0F; addr_i = 64'h4010; wdata_i = 64'h99;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_a_valid", 64'(a_valid_o), 64'd1);
            check("bp_gnt", 64'(gnt_o), 64'd0);
            check("bp_addr", a_address_o, 64'h4010);
            check("bp_mask", 64'(a_mask_o), 64'h0F);
            check("bp_idle", 64'(idle_o), 64'd1);
            tick();
        end
        a_ready_i = 1'b1;
        #1;
        check("bp_gnt_on_ready", 64'(gnt_o), 64'd1);
        s0 = a_source_o;
        tick();
        req_i = 1'b0;
        check("bp_allocated", 64'(idle_o), 64'd0);
        send_d(s0, 64'h0, 3'd0, 1'b0, 1'b0);
        check("bp_retired", 64'(idle_o), 64'd1);

        // Reset with two outstanding reads abandons them; late D is dropped
        issue(1'b0, 8'h00, 64'h5000, 64'h0, s0);
        issue(1'b0, 8'h00, 64'h5008, 64'h0, s1);
        check("rr_busy", 64'(idle_o), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rr_idle", 64'(idle_o), 64'd1);
        send_d(s0, 64'h5A, 3'd1, 1'b0, 1'b0);
        send_d(s1, 64'h5B, 3'd1, 1'b0, 1'b0);
        check("rr_no_rvalid", 64'(rvalid_o), 64'd0);
        tick();
        check("rr_still_idle", 64'(idle_o), 64'd1);

`ifdef L1_TLUL_BRIDGE_ERR_EN
        // Denied read: zero data with err pulse; corrupt write: err only
        push_exp(64'h0, 1'b1);
        issue(1'b0, 8'h00, 64'h6000, 64'h0, s0);
        send_d(s0, 64'hDEAD, 3'd1, 1'b1, 1'b0);
        check("err_rvalid", 64'(rvalid_o), 64'd1);
        check("err_rdata", rdata_o, 64'h0);
        check("err_flag", 64'(err_o), 64'd1);
        tick();
        check("err_pulse", 64'(err_o), 64'd0);
        issue(1'b1, 8'hFF, 64'h6008, 64'h1, s0);
        send_d(s0, 64'h0, 3'd0, 1'b0, 1'b1);
        check("err_wr_flag", 64'(err_o), 64'd1);
        check("err_wr_no_rvalid", 64'(rvalid_o), 64'd0);
        push_exp(64'h600D, 1'b0);
        issue(1'b0, 8'h00, 64'h6010, 64'h0, s0);
        send_d(s0, 64'h600D, 3'd1, 1'b0, 1'b0);
        check("ok_no_err", 64'(err_o), 64'd0);
`else
        // Without error support, denied responses pass data through
        push_exp(64'hDEAD, 1'b0);
        issue(1'b0, 8'h00, 64'h6000, 64'h0, s0);
        send_d(s0, 64'hDEAD, 3'd1, 1'b1, 1'b1);
        check("den_rvalid", 64'(rvalid_o), 64'd1);
        check("den_rdata", rdata_o, 64'hDEAD);
`endif

        tick();
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
